spi_master: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, single slave select.
- Converts a parallel start/tx_data request from the system side into an sclk/ss/mosi frame and returns the captured miso byte as rx_data with a one-cycle done pulse.
- Sits directly upstream of the SPI slave. It generates the sclk that clocks the slave and consumes the slave's miso.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 40 ++++
 rtl/spi_master.sv | 163 ++++++++++++++++
 tb/tb_spi_master.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 master: state encoding, bus mode, defaults.
package spi_pkg;

   // Controller states, also exported on the debug state port.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_SETUP    = 3'd1;
   localparam state_t ST_TRANSFER = 3'd2;
   localparam state_t ST_HOLD     = 3'd3;
   localparam state_t ST_GAP      = 3'd4;

   // Bus mode: sclk idles low, data sampled on the rising edge, MSB first.
   localparam logic CPOL      = 1'b0;
   localparam logic CPHA      = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CLK_DIV    = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled and pulses tick on the last count.
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   // Next count: hold at zero when disabled or cleared, wrap after the last count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, single slave select.
// Handshake: start is sampled only in IDLE (no ready; a request while busy is
// dropped). busy rises the cycle after acceptance; done pulses for one cycle
// with rx_data valid and busy already low. A start held high in the done
// cycle is accepted on the following edge.
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sclk,
   output logic                  ss,
   output logic                  mosi,
   input  logic                  miso,
   output state_t                state_o
);

   localparam int DW = DATA_WIDTH;
   localparam int BW = $clog2(DW);
   localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

   state_t          state_q, state_d;
   logic [DW-1:0]   tx_sh_q, tx_sh_d;
   logic [DW-1:0]   rx_sh_q, rx_sh_d;
   logic [DW-1:0]   rx_data_q, rx_data_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            sclk_q, sclk_d;
   logic            ss_q, ss_d;
   logic            mosi_q, mosi_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tick;

   // Timer runs in every active state and restarts on each state change.
   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != ST_IDLE),
      .clr_i  (state_d != state_q),
      .tick_o (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: every transition out of an active state waits for a tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_SETUP;
         ST_SETUP:    if (tick) state_d = ST_TRANSFER;
         ST_TRANSFER: if (tick && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = ST_HOLD;
         ST_HOLD:     if (tick) state_d = ST_GAP;
         ST_GAP:      if (tick) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; everything holds unless a state acts on it.
   always_comb begin
      sclk_d    = sclk_q;
      ss_d      = ss_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tx_sh_d   = tx_data;
               ss_d      = 1'b0;
               mosi_d    = tx_data[DW-1];
               busy_d    = 1'b1;
               bit_cnt_d = '0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               sclk_d  = ~CPOL;
               rx_sh_d = {rx_sh_q[DW-2:0], miso};
            end
         end
         ST_TRANSFER: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_sh_d = {rx_sh_q[DW-2:0], miso};
               end else if (bit_cnt_q != LAST_BIT) begin
                  tx_sh_d   = tx_sh_q << 1;
                  mosi_d    = tx_sh_q[DW-2];
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            sclk_d = CPOL;
            if (tick) ss_d = 1'b1;
         end
         ST_GAP: begin
            if (tick) begin
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               mosi_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q    <= CPOL;
         ss_q      <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         sclk_q    <= sclk_d;
         ss_q      <= ss_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign sclk    = sclk_q;
   assign ss      = ss_q;
   assign mosi    = mosi_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default instance (8 bit, divide by 4) plus a 16 bit,
// divide-by-1 instance. A behavioural slave serves miso from a word queue and
// a monitor rebuilds each mosi word from the sclk rising edges.
module tb_spi_master;
   import spi_pkg::*;

   localparam int DW8   = 8;
   localparam int CD8   = 4;
   localparam int DW16  = 16;
   localparam int CD16  = 1;
   localparam int LAT8  = CD8 * (2 * DW8 + 2);
   localparam int LAT16 = CD16 * (2 * DW16 + 2);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- DUT signals ----------------
   logic            start8 = 1'b0;
   logic [DW8-1:0]  tx8 = '0;
   logic [DW8-1:0]  rx8;
   logic            busy8, done8, sclk8, ss8, mosi8;
   logic            miso8 = 1'b0;
   state_t          st8;

   logic            start16 = 1'b0;
   logic [DW16-1:0] tx16 = '0;
   logic [DW16-1:0] rx16;
   logic            busy16, done16, sclk16, ss16, mosi16;
   logic            miso16 = 1'b0;
   state_t          st16;

   spi_master #(.DATA_WIDTH(DW8), .CLK_DIV(CD8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .rx_data(rx8),
      .busy(busy8), .done(done8), .sclk(sclk8), .ss(ss8), .mosi(mosi8),
      .miso(miso8), .state_o(st8)
   );

   spi_master #(.DATA_WIDTH(DW16), .CLK_DIV(CD16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .tx_data(tx16), .rx_data(rx16),
      .busy(busy16), .done(done16), .sclk(sclk16), .ss(ss16), .mosi(mosi16),
      .miso(miso16), .state_o(st16)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [DW8-1:0]  slave_q8[$];
   logic [DW8-1:0]  exp_q[$];
   logic [DW8-1:0]  exp_tx_q8[$];
   logic [DW16-1:0] slave_q16[$];
   logic [DW16-1:0] exp_rx_q16[$];
   logic [DW16-1:0] exp_tx_q16[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- slave model + monitor, 8 bit ----------------
   logic [DW8-1:0] cur_sl8 = '0;
   logic [DW8-1:0] cap8 = '0;
   int rises8 = 0, idx8 = DW8, ss_run8 = 0, done_cnt8 = 0;
   logic sclk_p8 = 1'b0, ss_p8 = 1'b1;

   always @(negedge clk) begin
      if (!ss8 && ss_p8) begin
         check("ss_gap8", 32'(ss_run8 >= CD8), 32'd1);
         if (slave_q8.size() > 0) cur_sl8 = slave_q8.pop_front();
         else cur_sl8 = '0;
         idx8 = 0; cap8 = '0; rises8 = 0;
      end
      if (sclk8 && !sclk_p8) begin
         cap8 = {cap8[DW8-2:0], mosi8};
         rises8++;
      end
      if (!sclk8 && sclk_p8) idx8++;
      miso8 = (idx8 < DW8) ? cur_sl8[DW8-1-idx8] : 1'b0;
      if (ss8) ss_run8++;
      else ss_run8 = 0;
      if (done8) begin
         done_cnt8++;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done8: done pulse with rx 0x%0h, expected no frame", rx8);
         end else begin
            logic [DW8-1:0] e_rx, e_tx;
            e_rx = exp_q.pop_front();
            e_tx = exp_tx_q8.pop_front();
            check("rx_data8", 32'(rx8), 32'(e_rx));
            check("mosi_word8", 32'(cap8), 32'(e_tx));
            check("rise_count8", 32'(rises8), 32'(DW8));
            check("busy_at_done8", 32'(busy8), 32'd0);
         end
      end
      sclk_p8 = sclk8;
      ss_p8   = ss8;
   end

   // ---------------- slave model + monitor, 16 bit ----------------
   logic [DW16-1:0] cur_sl16 = '0;
   logic [DW16-1:0] cap16 = '0;
   int rises16 = 0, idx16 = DW16, ss_run16 = 0, done_cnt16 = 0, last_rise16 = 0;
   logic sclk_p16 = 1'b0, ss_p16 = 1'b1;

   always @(negedge clk) begin
      if (!ss16 && ss_p16) begin
         check("ss_gap16", 32'(ss_run16 >= CD16), 32'd1);
         if (slave_q16.size() > 0) cur_sl16 = slave_q16.pop_front();
         else cur_sl16 = '0;
         idx16 = 0; cap16 = '0; rises16 = 0;
      end
      if (sclk16 && !sclk_p16) begin
         if (rises16 > 0) check("sclk_period16", 32'(cyc - last_rise16), 32'(2 * CD16));
         last_rise16 = cyc;
         cap16 = {cap16[DW16-2:0], mosi16};
         rises16++;
      end
      if (!sclk16 && sclk_p16) idx16++;
      miso16 = (idx16 < DW16) ? cur_sl16[DW16-1-idx16] : 1'b0;
      if (ss16) ss_run16++;
      else ss_run16 = 0;
      if (done16) begin
         done_cnt16++;
         if (exp_rx_q16.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done16: done pulse with rx 0x%0h, expected no frame", rx16);
         end else begin
            logic [DW16-1:0] e_rx, e_tx;
            e_rx = exp_rx_q16.pop_front();
            e_tx = exp_tx_q16.pop_front();
            check("rx_data16", 32'(rx16), 32'(e_rx));
            check("mosi_word16", 32'(cap16), 32'(e_tx));
            check("rise_count16", 32'(rises16), 32'(DW16));
            check("busy_at_done16", 32'(busy16), 32'd0);
         end
      end
      sclk_p16 = sclk16;
      ss_p16   = ss16;
   end

   // ---------------- driver tasks ----------------
   // Waits for done after an acceptance observed at cycle a; checks latency.
   task automatic wait_done8(input int a);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (done8) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen8", 32'(seen), 32'd1);
      if (seen) check("latency8", 32'(cyc - a), 32'(LAT8));
   endtask

   // Called at a negedge while idle: one complete frame with scoreboard entries.
   task automatic run8(input logic [DW8-1:0] tx, input logic [DW8-1:0] sl,
                       input logic [DW8-1:0] e_mosi, input logic [DW8-1:0] e_rx);
      int a;
      slave_q8.push_back(sl);
      exp_tx_q8.push_back(e_mosi);
      exp_q.push_back(e_rx);
      tx8 = tx;
      start8 = 1'b1;
      @(negedge clk);
      check("accept_busy8", 32'(busy8), 32'd1);
      a = cyc;
      start8 = 1'b0;
      wait_done8(a);
   endtask

   typedef struct {
      logic [DW8-1:0] tx;
      logic [DW8-1:0] sl;
      logic [DW8-1:0] exp_mosi;
      logic [DW8-1:0] exp_rx;
   } vec_t;

   vec_t vecs[12];

   // ---------------- main sequence ----------------
   initial begin
      int a, d0, r;
      bit hit;
      logic p;
      logic [DW8-1:0] t, s;

      // Vector table: MSB-first serialisation puts the tx word on mosi and the
      // slave word into rx_data.
      vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81};
      for (int i = 4; i < 12; i++) begin
         t = 8'($urandom_range(0, 255));
         s = 8'($urandom_range(0, 255));
         vecs[i] = '{t, s, t, s};
      end

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: all pins at rest for 20 cycles.
      check("reset_state8", 32'(st8), 32'(ST_IDLE));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_pins8", 32'({sclk8, ss8, mosi8, busy8, done8}), 32'(5'b01000));
         check("idle_rx8", 32'(rx8), 32'd0);
      end

      // Table-driven frames with random idle gaps.
      for (int i = 0; i < 12; i++) begin
         run8(vecs[i].tx, vecs[i].sl, vecs[i].exp_mosi, vecs[i].exp_rx);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Back-to-back: start held through done, tx changed while busy.
      repeat (5) @(negedge clk);
      d0 = done_cnt8;
      slave_q8.push_back(8'h96); exp_tx_q8.push_back(8'h01); exp_q.push_back(8'h96);
      slave_q8.push_back(8'h4B); exp_tx_q8.push_back(8'hFF); exp_q.push_back(8'h4B);
      tx8 = 8'h01;
      start8 = 1'b1;
      @(negedge clk);
      check("b2b_accept1", 32'(busy8), 32'd1);
      a = cyc;
      tx8 = 8'hFF;
      wait_done8(a);
      @(negedge clk);
      check("b2b_accept2", 32'(busy8), 32'd1);
      a = cyc;
      start8 = 1'b0;
      wait_done8(a);
      repeat (100) @(negedge clk);
      check("b2b_frames", 32'(done_cnt8 - d0), 32'd2);
      check("b2b_idle_busy", 32'(busy8), 32'd0);

      // Start pulses and tx_data changes mid-frame are ignored.
      d0 = done_cnt8;
      slave_q8.push_back(8'hC7); exp_tx_q8.push_back(8'h81); exp_q.push_back(8'hC7);
      tx8 = 8'h81;
      start8 = 1'b1;
      @(negedge clk);
      check("mid_accept", 32'(busy8), 32'd1);
      a = cyc;
      start8 = 1'b0;
      repeat (20) @(negedge clk);
      tx8 = 8'h00;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (10) @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(a);
      repeat (100) @(negedge clk);
      check("mid_single_done", 32'(done_cnt8 - d0), 32'd1);

      // Reset at the 4th rising sclk edge: immediate deselect, no done.
      d0 = done_cnt8;
      slave_q8.push_back(8'h3C);
      tx8 = 8'hE1;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      p = sclk8; r = 0; hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sclk8 && !p) r++;
         p = sclk8;
         if (r == 4) begin
            hit = 1'b1;
            break;
         end
      end
      check("fourth_rise_seen", 32'(hit), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_ss", 32'(ss8), 32'd1);
      check("rst_sclk", 32'(sclk8), 32'd0);
      check("rst_rx", 32'(rx8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("rst_no_done", 32'(done_cnt8 - d0), 32'd0);
      check("rst_rx_after", 32'(rx8), 32'd0);
      check("rst_state", 32'(st8), 32'(ST_IDLE));
      run8(8'h6D, 8'hB2, 8'h6D, 8'hB2);

      // 16 bit frame at divide-by-1.
      slave_q16.push_back(16'h5AA5);
      exp_tx_q16.push_back(16'hC3A5);
      exp_rx_q16.push_back(16'h5AA5);
      tx16 = 16'hC3A5;
      start16 = 1'b1;
      @(negedge clk);
      check("accept_busy16", 32'(busy16), 32'd1);
      a = cyc;
      start16 = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done16) begin
            hit = 1'b1;
            break;
         end
      end
      check("done_seen16", 32'(hit), 32'd1);
      if (hit) check("latency16", 32'(cyc - a), 32'(LAT16));

      repeat (20) @(negedge clk);
      check("pending8", 32'(exp_q.size()), 32'd0);
      check("pending16", 32'(exp_rx_q16.size()), 32'd0);
      check("done_total16", 32'(done_cnt16), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog bounding the whole run.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
